// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the multicycle memory-port sequencer.
// State encoding plus the IorD address-mux select values.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } state_t;

  localparam logic IORD_PC  = 1'b0;
  localparam logic IORD_ALU = 1'b1;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a zero flag; times one memory access.
// Load wins over decrement; decrement saturates at zero.
module mem_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-port sequencer arbitrating fetch vs load/store over one shared memory.
// Optional MEM_ACCESS_RR_EN selects round-robin arbitration instead of data-over-fetch priority.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fetch_req,
  input  logic data_req,
  input  logic data_we,
  output logic IorD,
  output logic mem_read,
  output logic mem_write,
  output logic ir_write,
  output logic pc_write,
  output logic mdr_write,
  output logic fetch_done,
  output logic data_done,
  output logic busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

  state_t r_state;
  state_t w_next_state;
  logic   r_iord;
  logic   w_next_iord;
  logic   w_start;
  logic   w_grant_data;
  logic   w_zero;
  logic   w_busy;
  logic   w_final;

`ifdef MEM_ACCESS_RR_EN
  // 0 = fetch was granted last, 1 = data was granted last
  logic r_last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b0;
    end else if (w_start) begin
      r_last_grant <= w_grant_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_iord  <= IORD_PC;
    end else begin
      r_state <= w_next_state;
      r_iord  <= w_next_iord;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_iord  = r_iord;
    w_start      = 1'b0;
    w_grant_data = 1'b0;
    case (r_state)
      IDLE: begin
`ifdef MEM_ACCESS_RR_EN
        w_grant_data = data_req && !(fetch_req && r_last_grant);
`else
        w_grant_data = data_req;
`endif
        if (w_grant_data) begin
          w_next_state = data_we ? STORE : LOAD;
          w_next_iord  = IORD_ALU;
          w_start      = 1'b1;
        end else if (fetch_req) begin
          w_next_state = FETCH;
          w_next_iord  = IORD_PC;
          w_start      = 1'b1;
        end
      end
      default: begin
        if (w_zero) begin
          w_next_state = IDLE;
        end
      end
    endcase
  end

  mem_wait_counter #(
    .CNT_W(CNT_W)
  ) u_wait_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_start),
    .i_load_val(LOAD_VAL),
    .i_dec     (w_busy),
    .o_zero    (w_zero)
  );

  // Counter is registered, so every output below is a decode of registers only.
  assign w_busy  = (r_state != IDLE);
  assign w_final = w_busy && w_zero;

  assign IorD       = r_iord;
  assign busy       = w_busy;
  assign mem_read   = (r_state == FETCH) || (r_state == LOAD);
  assign mem_write  = (r_state == STORE);
  assign ir_write   = (r_state == FETCH) && w_final;
  assign pc_write   = (r_state == FETCH) && w_final;
  assign fetch_done = (r_state == FETCH) && w_final;
  assign mdr_write  = (r_state == LOAD) && w_final;
  assign data_done  = ((r_state == LOAD) || (r_state == STORE)) && w_final;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised bench for mem_access_ctrl with an access-level reference model.
module tb_mem_access_ctrl;

  localparam int LAT = 2;
`ifdef MEM_ACCESS_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
  logic IorD, mem_read, mem_write, ir_write, pc_write, mdr_write, fetch_done, data_done, busy;

  logic rst1_n = 1'b1;
  logic fetch_req1 = 1'b0;
  logic IorD1, mem_read1, mem_write1, ir_write1, pc_write1, mdr_write1, fetch_done1, data_done1, busy1;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  bit dut1_finished = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LATENCY(LAT), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .data_req(data_req), .data_we(data_we),
    .IorD(IorD), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .mdr_write(mdr_write), .fetch_done(fetch_done),
    .data_done(data_done), .busy(busy)
  );

  mem_access_ctrl #(.MEM_LATENCY(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .fetch_req(fetch_req1), .data_req(1'b0), .data_we(1'b0),
    .IorD(IorD1), .mem_read(mem_read1), .mem_write(mem_write1), .ir_write(ir_write1),
    .pc_write(pc_write1), .mdr_write(mdr_write1), .fetch_done(fetch_done1),
    .data_done(data_done1), .busy(busy1)
  );

  // {IorD, mem_read, mem_write, ir_write, pc_write, mdr_write, fetch_done, data_done, busy}
  function automatic logic [8:0] outs();
    return {IorD, mem_read, mem_write, ir_write, pc_write, mdr_write, fetch_done, data_done, busy};
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Access-level model: what kind of access is in flight and how many cycles remain.
  typedef enum {M_NONE, M_FETCH, M_LOAD, M_STORE} m_kind_t;
  m_kind_t m_kind = M_NONE;
  int      m_rem = 0;
  bit      m_iord = 1'b0;
  bit      m_last_data = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kind = M_NONE; m_rem = 0; m_iord = 1'b0; m_last_data = 1'b0;
    end else if (m_kind == M_NONE) begin
      if (data_req && !(RR && fetch_req && m_last_data)) begin
        m_kind = data_we ? M_STORE : M_LOAD; m_rem = LAT; m_iord = 1'b1; m_last_data = 1'b1;
      end else if (fetch_req) begin
        m_kind = M_FETCH; m_rem = LAT; m_iord = 1'b0; m_last_data = 1'b0;
      end
    end else begin
      m_rem = m_rem - 1;
      if (m_rem == 0) m_kind = M_NONE;
    end
  end

  function automatic logic [8:0] model_outs();
    bit fin;
    fin = (m_kind != M_NONE) && (m_rem == 1);
    return {m_iord,
            (m_kind == M_FETCH) || (m_kind == M_LOAD),
            (m_kind == M_STORE),
            (m_kind == M_FETCH) && fin,
            (m_kind == M_FETCH) && fin,
            (m_kind == M_LOAD) && fin,
            (m_kind == M_FETCH) && fin,
            ((m_kind == M_LOAD) || (m_kind == M_STORE)) && fin,
            (m_kind != M_NONE)};
  endfunction

  always @(negedge clk) begin
    if (chk_en) chk("model", outs(), model_outs());
  end

  task automatic nclk();
    @(negedge clk);
  endtask

  // Latency-1 instance under continuous fetch requests.
  initial begin
    #1 rst1_n = 1'b0;
    repeat (2) nclk();
    rst1_n = 1'b1;
    fetch_req1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nclk();
      chk("lat1_fetch_done", {8'd0, fetch_done1}, {8'd0, (i % 2) == 0});
      chk("lat1_iord_read", {7'd0, IorD1, mem_read1}, {7'd0, 1'b0, (i % 2) == 0});
    end
    dut1_finished = 1'b1;
  end

  initial begin
    #1 rst_n = 1'b0;
    #2 chk("reset_outs", outs(), 9'b0);
    repeat (2) nclk();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Fetch
    fetch_req = 1'b1;
    nclk(); chk("fetch_c1", outs(), 9'b010000001);
    nclk(); chk("fetch_c2", outs(), 9'b010110101); fetch_req = 1'b0;
    nclk(); chk("fetch_idle", outs(), 9'b000000000);

    // Load
    data_req = 1'b1; data_we = 1'b0;
    nclk(); chk("load_c1", outs(), 9'b110000001);
    nclk(); chk("load_c2", outs(), 9'b110001011); data_req = 1'b0;
    nclk(); chk("load_idle", outs(), 9'b100000000);

    // Store
    data_req = 1'b1; data_we = 1'b1;
    nclk(); chk("store_c1", outs(), 9'b101000001); data_we = 1'b0;
    nclk(); chk("store_c2", outs(), 9'b101000011); data_req = 1'b0;
    nclk(); chk("store_idle", outs(), 9'b100000000);

    // Simultaneous requests
    fetch_req = 1'b1; data_req = 1'b1; data_we = 1'b0;
`ifdef MEM_ACCESS_RR_EN
    nclk(); chk("both_first_c1", outs(), 9'b010000001);
    nclk(); chk("both_first_c2", outs(), 9'b010110101); fetch_req = 1'b0;
    nclk(); chk("both_turn", outs(), 9'b000000000);
    nclk(); chk("both_second_c1", outs(), 9'b110000001);
    nclk(); chk("both_second_c2", outs(), 9'b110001011); data_req = 1'b0;
    nclk(); chk("both_idle", outs(), 9'b100000000);
`else
    nclk(); chk("both_first_c1", outs(), 9'b110000001);
    nclk(); chk("both_first_c2", outs(), 9'b110001011); data_req = 1'b0;
    nclk(); chk("both_turn", outs(), 9'b100000000);
    nclk(); chk("both_second_c1", outs(), 9'b010000001);
    nclk(); chk("both_second_c2", outs(), 9'b010110101); fetch_req = 1'b0;
    nclk(); chk("both_idle", outs(), 9'b000000000);
`endif

    // Reset in the first cycle of a fetch
    data_req = 1'b1; data_we = 1'b0;
    nclk(); data_req = 1'b0; fetch_req = 1'b1;
    nclk(); nclk();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_fetch", outs(), 9'b000000000);
    nclk(); chk("reset_held", outs(), 9'b000000000);
    rst_n = 1'b1;
    nclk(); chk("refetch_c1", outs(), 9'b010000001);
    nclk(); chk("refetch_c2", outs(), 9'b010110101); fetch_req = 1'b0;
    nclk(); chk("refetch_idle", outs(), 9'b000000000);

    // Randomised traffic with occasional asynchronous resets
    for (int i = 0; i < 800; i++) begin
      fetch_req = ($urandom_range(0, 9) < 6);
      data_req  = ($urandom_range(0, 9) < 4);
      data_we   = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 79) == 0) begin
        #2 rst_n = 1'b0;
        nclk();
        rst_n = 1'b1;
      end else begin
        nclk();
      end
    end

    fetch_req = 1'b0; data_req = 1'b0;
    repeat (LAT + 2) nclk();
    if (!dut1_finished) begin
      n_chk++; n_fail++;
      $display("FAIL lat1_run: got unfinished expected finished");
    end
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
